ir_packet_tx: RTL and testbench

Parametrised IR packet transmitter and the next generation of the car IR driver. It generates the modulated IR carrier and serialises one packet (START mark, SELECT mark, then one mark per command bit, with a GAP after every mark). Compared with the fixed four-command state machine, it adds:
- an arbitrary command width;
- run-time programmable carrier and burst lengths, latched per packet;
- a REQ/ACK/BUSY/DONE handshake;
- an optional periodic auto-repeat mode.

It sits between the command/car-select logic and the IR LED pin.

---
 rtl/ir_packet_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_ir_packet_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_packet_tx.sv
// IR packet transmitter: modulated carrier plus START/SELECT/command-bit marks
// separated by gaps, with a REQ/ACK handshake and optional periodic auto-repeat.
module ir_packet_tx #(
    parameter int CMD_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int DIV_W   = 16,
    parameter int REP_W   = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [DIV_W-1:0]   CARRIER_HALF,
    input  logic [CNT_W-1:0]   START_LEN,
    input  logic [CNT_W-1:0]   GAP_LEN,
    input  logic [CNT_W-1:0]   SELECT_LEN,
    input  logic [CNT_W-1:0]   ASSERT_LEN,
    input  logic [CNT_W-1:0]   DEASSERT_LEN,
    input  logic               REPEAT_EN,
    input  logic [REP_W-1:0]   REPEAT_PERIOD,
    input  logic [CMD_LEN-1:0] CMD,
    input  logic               REQ,
    output logic               ACK,
    output logic               BUSY,
    output logic               DONE,
    output logic               IR_LED
);

    localparam int SEG_LAST = 2 * CMD_LEN + 3;
    localparam int SEG_W    = $clog2(SEG_LAST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARK    = 2'd1,
        SPACE   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t             state_r;
    logic [SEG_W-1:0]   seg_r;
    logic [DIV_W-1:0]   div_r;
    logic [DIV_W-1:0]   half_r;
    logic               car_r;
    logic [CNT_W-1:0]   burst_r;
    logic [CNT_W-1:0]   start_len_r;
    logic [CNT_W-1:0]   gap_len_r;
    logic [CNT_W-1:0]   select_len_r;
    logic [CNT_W-1:0]   assert_len_r;
    logic [CNT_W-1:0]   deassert_len_r;
    logic [REP_W-1:0]   rep_r;
    logic [REP_W-1:0]   period_r;
    logic [CMD_LEN-1:0] cmd_r;

    logic               div_end_s;
    logic               car_next_s;
    logic               tick_s;
    logic               cmd_bit_s;
    logic               seg_done_s;
    logic               last_seg_s;
    logic               rep_hit_s;
    logic               load_s;
    logic [DIV_W-1:0]   div_next_s;
    logic [CNT_W-1:0]   seg_len_s;
    logic [CNT_W-1:0]   burst_inc_s;
    logic [REP_W-1:0]   rep_inc_s;

    function automatic logic [CNT_W-1:0] len_nz(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [DIV_W-1:0] div_nz(input logic [DIV_W-1:0] v);
        return (v == '0) ? DIV_W'(1) : v;
    endfunction

    // A tick marks the carrier rising again, i.e. one full carrier cycle completed
    assign div_end_s   = (div_r == (half_r - DIV_W'(1)));
    assign div_next_s  = div_end_s ? '0 : div_r + DIV_W'(1);
    assign car_next_s  = div_end_s ? ~car_r : car_r;
    assign tick_s      = div_end_s & ~car_r;
    assign last_seg_s  = (seg_r == SEG_W'(SEG_LAST));
    assign seg_done_s  = tick_s & (({1'b0, burst_r} + (CNT_W + 1)'(1)) >= {1'b0, seg_len_s});
    assign rep_hit_s   = (({1'b0, rep_r} + (REP_W + 1)'(1)) >= {1'b0, period_r});
    assign burst_inc_s = (&burst_r) ? burst_r : burst_r + CNT_W'(1);
    assign rep_inc_s   = (&rep_r) ? rep_r : rep_r + REP_W'(1);
    assign load_s      = REQ & ((state_r == IDLE) |
                                ((state_r == HOLDOFF) & REPEAT_EN & tick_s & rep_hit_s));

    // Length of the current segment: odd segments are gaps, even ones START/SELECT/bit k
    always_comb begin
        cmd_bit_s = 1'b0;
        for (int k = 0; k < CMD_LEN; k++) begin
            cmd_bit_s = cmd_bit_s | ((seg_r == SEG_W'(2 * k + 4)) & cmd_r[k]);
        end
        if (seg_r[0]) begin
            seg_len_s = gap_len_r;
        end else if (seg_r == '0) begin
            seg_len_s = start_len_r;
        end else if (seg_r == SEG_W'(2)) begin
            seg_len_s = select_len_r;
        end else if (cmd_bit_s) begin
            seg_len_s = assert_len_r;
        end else begin
            seg_len_s = deassert_len_r;
        end
    end

    // Control FSM, carrier divider, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r        <= IDLE;
            seg_r          <= '0;
            div_r          <= '0;
            half_r         <= '0;
            car_r          <= 1'b0;
            burst_r        <= '0;
            rep_r          <= '0;
            start_len_r    <= '0;
            gap_len_r      <= '0;
            select_len_r   <= '0;
            assert_len_r   <= '0;
            deassert_len_r <= '0;
            period_r       <= '0;
            cmd_r          <= '0;
            ACK            <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            IR_LED         <= 1'b0;
        end else begin
            ACK  <= load_s;
            DONE <= 1'b0;
            if (load_s) begin
                half_r         <= div_nz(CARRIER_HALF);
                start_len_r    <= len_nz(START_LEN);
                gap_len_r      <= len_nz(GAP_LEN);
                select_len_r   <= len_nz(SELECT_LEN);
                assert_len_r   <= len_nz(ASSERT_LEN);
                deassert_len_r <= len_nz(DEASSERT_LEN);
                period_r       <= REPEAT_PERIOD;
                cmd_r          <= CMD;
            end
            case (state_r)
                IDLE: begin
                    if (REQ) begin
                        state_r <= MARK;
                        seg_r   <= '0;
                        div_r   <= '0;
                        car_r   <= 1'b1;
                        burst_r <= '0;
                        rep_r   <= '0;
                        BUSY    <= 1'b1;
                        IR_LED  <= 1'b1;
                    end else begin
                        BUSY    <= 1'b0;
                        IR_LED  <= 1'b0;
                    end
                end
                MARK, SPACE: begin
                    div_r <= div_next_s;
                    car_r <= car_next_s;
                    if (tick_s) begin
                        rep_r <= rep_inc_s;
                    end
                    if (seg_done_s) begin
                        burst_r <= '0;
                        if (!last_seg_s) begin
                            seg_r   <= seg_r + SEG_W'(1);
                            state_r <= seg_r[0] ? MARK : SPACE;
                            IR_LED  <= seg_r[0] & car_next_s;
                        end else if (REPEAT_EN && rep_hit_s) begin
                            // period already elapsed: next packet follows with no holdoff
                            state_r <= MARK;
                            seg_r   <= '0;
                            rep_r   <= '0;
                            IR_LED  <= 1'b1;
                        end else if (REPEAT_EN) begin
                            state_r <= HOLDOFF;
                            IR_LED  <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            BUSY    <= 1'b0;
                            DONE    <= 1'b1;
                            IR_LED  <= 1'b0;
                        end
                    end else begin
                        if (tick_s) begin
                            burst_r <= burst_inc_s;
                        end
                        IR_LED <= (state_r == MARK) & car_next_s;
                    end
                end
                HOLDOFF: begin
                    if (!REPEAT_EN) begin
                        state_r <= IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        IR_LED  <= 1'b0;
                    end else if (tick_s && rep_hit_s) begin
                        state_r <= MARK;
                        seg_r   <= '0;
                        div_r   <= '0;
                        car_r   <= 1'b1;
                        burst_r <= '0;
                        rep_r   <= '0;
                        IR_LED  <= 1'b1;
                    end else begin
                        div_r  <= div_next_s;
                        car_r  <= car_next_s;
                        IR_LED <= 1'b0;
                        if (tick_s) begin
                            rep_r <= rep_inc_s;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    BUSY    <= 1'b0;
                    IR_LED  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_packet_tx.sv
// Bench for ir_packet_tx: the expected IR_LED waveform of each packet is built
// segment by segment from the settings and compared cycle by cycle with handshakes.
module tb_ir_packet_tx;

    localparam int CMD_LEN = 4;
    localparam int CNT_W   = 8;
    localparam int DIV_W   = 16;
    localparam int REP_W   = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [DIV_W-1:0]   carrier_half;
    logic [CNT_W-1:0]   start_len, gap_len, select_len, assert_len, deassert_len;
    logic               repeat_en;
    logic [REP_W-1:0]   repeat_period;
    logic [CMD_LEN-1:0] cmd;
    logic               req;
    logic               ack, busy, done, ir_led;

    int errors = 0;
    int checks = 0;
    bit pkt_q[$];
    int pkt_car;
    int pkt_h;
    int hold;

    always #5 clk = ~clk;

    ir_packet_tx #(
        .CMD_LEN(CMD_LEN), .CNT_W(CNT_W), .DIV_W(DIV_W), .REP_W(REP_W)
    ) dut (
        .CLK(clk), .RESET(reset_n), .CARRIER_HALF(carrier_half),
        .START_LEN(start_len), .GAP_LEN(gap_len), .SELECT_LEN(select_len),
        .ASSERT_LEN(assert_len), .DEASSERT_LEN(deassert_len),
        .REPEAT_EN(repeat_en), .REPEAT_PERIOD(repeat_period), .CMD(cmd),
        .REQ(req), .ACK(ack), .BUSY(busy), .DONE(done), .IR_LED(ir_led)
    );

    function automatic int nz(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Expected IR_LED per CLK cycle for one packet built from the current inputs
    task automatic build_pkt();
        int lens[CMD_LEN+2];
        int g;
        pkt_q.delete();
        pkt_car = 0;
        pkt_h   = nz(int'(carrier_half));
        g       = nz(int'(gap_len));
        lens[0] = nz(int'(start_len));
        lens[1] = nz(int'(select_len));
        for (int k = 0; k < CMD_LEN; k++)
            lens[k+2] = cmd[k] ? nz(int'(assert_len)) : nz(int'(deassert_len));
        for (int m = 0; m < CMD_LEN + 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                int len;
                len = (p == 0) ? lens[m] : g;
                pkt_car += len;
                for (int c = 0; c < len; c++)
                    for (int j = 0; j < 2 * pkt_h; j++)
                        pkt_q.push_back((p == 0) && (j < pkt_h));
            end
        end
    endtask

    function automatic int holdoff_cycles(input int period);
        return (period > pkt_car) ? (period - pkt_car) * 2 * pkt_h : 0;
    endfunction

    task automatic check_cycle(input string tag, input bit e_ir, input bit e_busy,
                               input bit e_ack, input bit e_done);
        @(posedge clk);
        #1;
        checks++;
        assert (ir_led === e_ir) else begin
            errors++;
            $error("FAIL %s IR_LED: got %0b want %0b", tag, ir_led, e_ir);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++;
            $error("FAIL %s BUSY: got %0b want %0b", tag, busy, e_busy);
        end
        checks++;
        assert (ack === e_ack) else begin
            errors++;
            $error("FAIL %s ACK: got %0b want %0b", tag, ack, e_ack);
        end
        checks++;
        assert (done === e_done) else begin
            errors++;
            $error("FAIL %s DONE: got %0b want %0b", tag, done, e_done);
        end
    endtask

    task automatic scramble_inputs();
        carrier_half  = DIV_W'($urandom_range(0, 7));
        start_len     = CNT_W'($urandom_range(0, 7));
        gap_len       = CNT_W'($urandom_range(0, 7));
        select_len    = CNT_W'($urandom_range(0, 7));
        assert_len    = CNT_W'($urandom_range(0, 7));
        deassert_len  = CNT_W'($urandom_range(0, 7));
        repeat_period = REP_W'($urandom_range(0, 40));
        cmd           = CMD_LEN'($urandom);
    endtask

    task automatic expect_pkt(input string tag, input bit first_ack,
                              input bit scramble, input int drop_at);
        for (int i = 0; i < pkt_q.size(); i++) begin
            check_cycle(tag, pkt_q[i], 1'b1, first_ack && (i == 0), 1'b0);
            if (i == 0) begin
                req = 1'b0;
                if (scramble) scramble_inputs();
            end
            if (i == drop_at) repeat_en = 1'b0;
        end
    endtask

    task automatic expect_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) check_cycle(tag, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_basic();
        carrier_half = 16'd2;
        start_len    = 8'd3;
        gap_len      = 8'd1;
        select_len   = 8'd2;
        assert_len   = 8'd2;
        deassert_len = 8'd1;
        cmd          = 4'b0101;
    endtask

    initial begin
        reset_n       = 1'b0;
        req           = 1'b0;
        repeat_en     = 1'b0;
        repeat_period = 16'd0;
        set_basic();

        // reset state
        check_cycle("reset0", 1'b0, 1'b0, 1'b0, 1'b0);
        check_cycle("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        check_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // basic packet; REQ raised in the last cycle must wait for DONE
        build_pkt();
        req = 1'b1;
        expect_pkt("basic", 1'b1, 1'b0, -1);
        req = 1'b1;
        check_cycle("basic_done", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_pkt("b2b", 1'b1, 1'b0, -1);
        check_cycle("b2b_done", 1'b0, 1'b0, 1'b0, 1'b1);
        check_cycle("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // auto-repeat with holdoff, latched CMD, update at restart, exit
        repeat_en     = 1'b1;
        repeat_period = 16'd25;
        build_pkt();
        hold = holdoff_cycles(25);
        req = 1'b1;
        expect_pkt("rep1", 1'b1, 1'b0, -1);
        cmd = 4'b1111;
        expect_hold("rep1_hold", hold);
        expect_pkt("rep2", 1'b0, 1'b0, -1);
        req = 1'b1;
        expect_hold("rep2_hold", hold);
        build_pkt();
        expect_pkt("rep3_new_cmd", 1'b1, 1'b0, -1);
        expect_hold("rep3_hold", 5);
        repeat_en = 1'b0;
        check_cycle("rep_exit", 1'b0, 1'b0, 1'b0, 1'b1);
        check_cycle("rep_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // short repeat period: back-to-back packets
        set_basic();
        repeat_en     = 1'b1;
        repeat_period = 16'd10;
        build_pkt();
        req = 1'b1;
        expect_pkt("short1", 1'b1, 1'b0, -1);
        expect_hold("short_hold", holdoff_cycles(10));
        expect_pkt("short2", 1'b0, 1'b0, 20);
        check_cycle("short_done", 1'b0, 1'b0, 1'b0, 1'b1);

        // reset in the middle of a packet
        build_pkt();
        req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            check_cycle("rst_pkt", pkt_q[i], 1'b1, i == 0, 1'b0);
            if (i == 0) req = 1'b0;
        end
        reset_n = 1'b0;
        check_cycle("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        check_cycle("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);
        req = 1'b1;
        expect_pkt("post_rst", 1'b1, 1'b0, -1);
        check_cycle("post_rst_done", 1'b0, 1'b0, 1'b0, 1'b1);

        // zero settings behave as ones
        carrier_half = 16'd0;
        start_len    = 8'd0;
        gap_len      = 8'd0;
        select_len   = 8'd0;
        assert_len   = 8'd0;
        deassert_len = 8'd0;
        cmd          = CMD_LEN'($urandom);
        build_pkt();
        req = 1'b1;
        expect_pkt("zero", 1'b1, 1'b0, -1);
        check_cycle("zero_done", 1'b0, 1'b0, 1'b0, 1'b1);

        // random single packets with inputs scrambled after ACK
        for (int r = 0; r < 4; r++) begin
            scramble_inputs();
            build_pkt();
            req = 1'b1;
            expect_pkt("rand", 1'b1, 1'b1, -1);
            check_cycle("rand_done", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // random repeat period
        scramble_inputs();
        repeat_en = 1'b1;
        build_pkt();
        hold = holdoff_cycles(int'(repeat_period));
        req = 1'b1;
        expect_pkt("rrep1", 1'b1, 1'b1, -1);
        expect_hold("rrep_hold", hold);
        expect_pkt("rrep2", 1'b0, 1'b0, pkt_q.size() / 2);
        check_cycle("rrep_done", 1'b0, 1'b0, 1'b0, 1'b1);
        check_cycle("rrep_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
